seq_gen: RTL and testbench
==========================

Name: seq_gen

Overview:
Serial pattern transmitter, the source side of the serial bit-stream detectors. Accepts a parallel word, bit length and repeat count over a valid/ready handshake. Emits the word MSB-first on a 1-bit serial line, one bit per clock, with optional idle gaps between repetitions. Used to drive detector inputs in-system and on the bench.

Parameters:
WIDTH, 16, maximum word length in bits
LEN_W, 5, width of in_len; must satisfy 2**LEN_W > WIDTH
REP_W, 4, width of in_rep
GAP, 0, idle cycles inserted between repetitions (0 = back-to-back)
IDLE_BIT, 1'b0, level driven on dout when not shifting

Ports:
clk  input  1  clock; all logic on posedge
rst  input  1  synchronous reset, active-high
in_valid  input  1  request to load a word
in_ready  output  1  = (state==IDLE) && !abort; combinational
in_data  input  WIDTH  pattern; bits [in_len-1:0] are sent, MSB first
in_len  input  LEN_W  bits to send; 0 or values > WIDTH mean WIDTH
in_rep  input  REP_W  extra repetitions; total sends = in_rep+1
abort  input  1  cancel the burst in progress
dout  output  1  serial bit
dout_valid  output  1  dout carries a pattern bit this cycle
busy  output  1  high in SHIFT/GAP/DONE
done  output  1  one-cycle pulse at burst end

Behaviour:
- Interface: single clock; reset is synchronous and active-high.
- Reset (any state, wins over everything): state=IDLE; dout=IDLE_BIT, dout_valid=0, busy=0, done=0; counters and shift register cleared. in_ready is high in the cycle after rst falls.
- States, one-hot: IDLE, SHIFT, GAP, DONE.
- IDLE: when in_valid && in_ready at edge T:
  - capture shreg = in_data << (WIDTH-len), len, rep, and the original word for reloads;
  - go to SHIFT; the first bit is valid at T+1.
- SHIFT:
  - dout = shreg[WIDTH-1], dout_valid=1; shift left once per cycle; bit counter counts up to len.
  - On the last bit: if repetitions remain, go to GAP (GAP>0) or reload shreg and stay in SHIFT (GAP=0, no bubble). Otherwise go to DONE.
- GAP: dout=IDLE_BIT, dout_valid=0 for exactly GAP cycles; then reload shreg and go to SHIFT.
- DONE: done=1, dout_valid=0 for one cycle; then IDLE.
- Timing for a single send: last bit at T+len; done at T+len+1; in_ready high at T+len+2.
- Registered outputs: dout, dout_valid, done.
- abort:
  - in SHIFT/GAP/DONE: state=IDLE next edge; dout_valid=0 and dout=IDLE_BIT from the next cycle; no done pulse.
  - in IDLE: blocks acceptance that cycle.
- in_valid outside IDLE is ignored; no queuing.
- Repeat counter saturates at 0; rep=2**REP_W-1 gives 2**REP_W sends.

Optional Feature:
- Macro: SEQ_GEN_EXPECT_EN.
- Defined:
  - Adds output expect_flag (1 bit), fed by a 4-bit history of emitted valid bits.
  - expect_flag=1 for one cycle, the cycle after the valid bit that completes 1101 or 0110; overlapping matches count.
  - GAP cycles do not shift the history. History clears on rst, abort and entry to IDLE.
  - Gives the bench the expected detector flag.
- Undefined: the port and the history logic are absent; all other behaviour is identical.

Decomposition:
- Package seq_pkg:
  - state one-hot constants ST_IDLE, ST_SHIFT, ST_GAP, ST_DONE;
  - pattern constants PAT_A=4'b1101, PAT_B=4'b0110 (shared with the detectors).
- Optional sub-module seq_gen_hist: 4-bit history plus PAT_A/PAT_B match, instantiated only under SEQ_GEN_EXPECT_EN.

Test Plan:
1. in_data=16'h000D, in_len=4, in_rep=0, GAP=0, accept at T -> dout 1,1,0,1 valid T+1..T+4; done at T+5; in_ready high at T+6.
2. in_data=16'hA5C3, in_len=0 -> 16 valid bits 1010_0101_1100_0011 on consecutive cycles, then done.
3. in_data=4'b0110, in_len=4, in_rep=2, GAP=2 -> 0110, 2 cycles valid=0 with dout=IDLE_BIT, 0110, gap, 0110; exactly 12 valid bits; one done.
4. 8-bit word, abort asserted during the 3rd bit -> dout_valid=0 from the next cycle, no done, in_ready=1; a new word with in_valid=1 that same abort cycle is not accepted.
5. rst pulsed mid-SHIFT with in_valid held high -> all outputs at reset values next cycle; a new word is accepted the cycle after rst falls; its first bit appears one cycle later.
6. SEQ_GEN_EXPECT_EN, in_data=7'b1101101, in_len=7 -> expect_flag high the cycles after bits 4, 6 and 7; with GAP=3, in_rep=1, no false match across the gap.

Source files
------------

// File: rtl/seq_pkg.sv
// Shared definitions for the serial pattern transmitter and its detector peers:
// one-hot FSM encoding and the two 4-bit reference patterns.
package seq_pkg;

    typedef enum logic [3:0] {
        ST_IDLE  = 4'b0001,
        ST_SHIFT = 4'b0010,
        ST_GAP   = 4'b0100,
        ST_DONE  = 4'b1000
    } state_t;

    localparam logic [3:0] PAT_A = 4'b1101;
    localparam logic [3:0] PAT_B = 4'b0110;

    function automatic logic pat_match(input logic [3:0] hist);
        return (hist == PAT_A) || (hist == PAT_B);
    endfunction

endpackage

// File: rtl/seq_gen_hist.sv
// Expected-detector model: 4-bit history of emitted bits with PAT_A/PAT_B match.
// Only built when SEQ_GEN_EXPECT_EN is defined.
`ifdef SEQ_GEN_EXPECT_EN
module seq_gen_hist
    import seq_pkg::*;
(
    input  logic clk,
    input  logic rst,
    input  logic clear,
    input  logic sbit_valid,
    input  logic sbit,
    output logic flag
);

    logic [3:0] hist;
    logic [3:0] hist_nx;
    logic [1:0] fill;

    assign hist_nx = {hist[2:0], sbit};

    // fill tracks real bits held so a cleared (zero) history cannot fake a 0110
    always_ff @(posedge clk) begin
        if (rst || clear) begin
            hist <= '0;
            fill <= '0;
            flag <= 1'b0;
        end else if (sbit_valid) begin
            hist <= hist_nx;
            if (fill != 2'd3) begin
                fill <= fill + 2'd1;
            end
            flag <= (fill == 2'd3) && pat_match(hist_nx);
        end else begin
            flag <= 1'b0;
        end
    end

endmodule
`endif

// File: rtl/seq_gen.sv
// Serial pattern transmitter: loads a word over valid/ready and shifts it out MSB-first,
// repeating with optional idle gaps. SEQ_GEN_EXPECT_EN adds the expect_flag output.
module seq_gen
    import seq_pkg::*;
#(
    parameter int unsigned WIDTH    = 16,
    parameter int unsigned LEN_W    = 5,
    parameter int unsigned REP_W    = 4,
    parameter int unsigned GAP      = 0,
    parameter logic        IDLE_BIT = 1'b0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_data,
    input  logic [LEN_W-1:0] in_len,
    input  logic [REP_W-1:0] in_rep,
    input  logic             abort,
    output logic             dout,
    output logic             dout_valid,
    output logic             busy,
    output logic             done
`ifdef SEQ_GEN_EXPECT_EN
    ,
    output logic             expect_flag
`endif
);

    localparam int unsigned GAP_W = (GAP > 1) ? $clog2(GAP) : 1;

    state_t           state, state_nx;
    logic [WIDTH-1:0] shreg, shreg_nx;
    logic [WIDTH-1:0] word, word_nx;
    logic [LEN_W-1:0] len_q, len_nx;
    logic [LEN_W-1:0] cnt, cnt_nx;
    logic [LEN_W-1:0] eff_len;
    logic [REP_W-1:0] rep_q, rep_nx;
    logic [GAP_W-1:0] gap_cnt, gap_nx;
    logic             dout_nx, dout_valid_nx, done_nx;

    assign eff_len  = ((in_len == '0) || (in_len > LEN_W'(WIDTH))) ? LEN_W'(WIDTH) : in_len;
    assign in_ready = (state == ST_IDLE) && !abort;
    assign busy     = (state != ST_IDLE);

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= ST_IDLE;
            shreg      <= '0;
            word       <= '0;
            len_q      <= '0;
            cnt        <= '0;
            rep_q      <= '0;
            gap_cnt    <= '0;
            dout       <= IDLE_BIT;
            dout_valid <= 1'b0;
            done       <= 1'b0;
        end else begin
            state      <= state_nx;
            shreg      <= shreg_nx;
            word       <= word_nx;
            len_q      <= len_nx;
            cnt        <= cnt_nx;
            rep_q      <= rep_nx;
            gap_cnt    <= gap_nx;
            dout       <= dout_nx;
            dout_valid <= dout_valid_nx;
            done       <= done_nx;
        end
    end

    // shreg[MSB] is the bit on dout while in SHIFT; word holds the MSB-aligned copy for reloads
    always_comb begin
        state_nx = state;
        shreg_nx = shreg;
        word_nx  = word;
        len_nx   = len_q;
        cnt_nx   = cnt;
        rep_nx   = rep_q;
        gap_nx   = gap_cnt;

        unique case (state)
            ST_IDLE: begin
                if (in_valid && !abort) begin
                    shreg_nx = in_data << (LEN_W'(WIDTH) - eff_len);
                    word_nx  = in_data << (LEN_W'(WIDTH) - eff_len);
                    len_nx   = eff_len;
                    rep_nx   = in_rep;
                    cnt_nx   = LEN_W'(1);
                    state_nx = ST_SHIFT;
                end
            end
            ST_SHIFT: begin
                if (cnt == len_q) begin
                    if (rep_q != '0) begin
                        rep_nx = rep_q - REP_W'(1);
                        if (GAP > 0) begin
                            gap_nx   = '0;
                            state_nx = ST_GAP;
                        end else begin
                            shreg_nx = word;
                            cnt_nx   = LEN_W'(1);
                        end
                    end else begin
                        state_nx = ST_DONE;
                    end
                end else begin
                    shreg_nx = shreg << 1;
                    cnt_nx   = cnt + LEN_W'(1);
                end
            end
            ST_GAP: begin
                if (gap_cnt == GAP_W'(GAP - 1)) begin
                    shreg_nx = word;
                    cnt_nx   = LEN_W'(1);
                    state_nx = ST_SHIFT;
                end else begin
                    gap_nx = gap_cnt + GAP_W'(1);
                end
            end
            ST_DONE: begin
                state_nx = ST_IDLE;
            end
            default: begin
                state_nx = ST_IDLE;
            end
        endcase

        if (abort && (state != ST_IDLE)) begin
            state_nx = ST_IDLE;
        end

        dout_valid_nx = (state_nx == ST_SHIFT);
        dout_nx       = dout_valid_nx ? shreg_nx[WIDTH-1] : IDLE_BIT;
        done_nx       = (state_nx == ST_DONE);
    end

`ifdef SEQ_GEN_EXPECT_EN
    logic hist_clear;

    assign hist_clear = (state == ST_IDLE) || abort;

    seq_gen_hist u_hist (
        .clk        (clk),
        .rst        (rst),
        .clear      (hist_clear),
        .sbit_valid (dout_valid),
        .sbit       (dout),
        .flag       (expect_flag)
    );
`endif

endmodule

// File: tb/tb_seq_gen.sv
// Self-checking bench for seq_gen: three instances (GAP 0/2/3) share one stimulus stream
// and are compared each cycle against a per-instance schedule-based reference model.
module tb_seq_gen;

    localparam int NDUT = 3;
    localparam int SMAX = 512;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        in_valid = 1'b0;
    logic [15:0] in_data = '0;
    logic [4:0]  in_len = '0;
    logic [3:0]  in_rep = '0;
    logic        abort = 1'b0;

    logic [NDUT-1:0] in_ready, dout, dout_valid, busy, done;
`ifdef SEQ_GEN_EXPECT_EN
    logic [NDUT-1:0] expect_flag;
`endif

    int tests = 0;
    int failed = 0;

    always #5 clk = ~clk;

    for (genvar k = 0; k < NDUT; k++) begin : g_dut
        seq_gen #(
            .WIDTH    (16),
            .LEN_W    (5),
            .REP_W    (4),
            .GAP      ((k == 0) ? 0 : k + 1),
            .IDLE_BIT ((k == 1) ? 1'b1 : 1'b0)
        ) u_dut (
            .clk        (clk),
            .rst        (rst),
            .in_valid   (in_valid),
            .in_ready   (in_ready[k]),
            .in_data    (in_data),
            .in_len     (in_len),
            .in_rep     (in_rep),
            .abort      (abort),
            .dout       (dout[k]),
            .dout_valid (dout_valid[k]),
            .busy       (busy[k]),
            .done       (done[k])
`ifdef SEQ_GEN_EXPECT_EN
            ,
            .expect_flag (expect_flag[k])
`endif
        );
    end

    // Reference model: each burst is expanded into a per-cycle schedule of
    // entries 0/1 = data bit, 2 = gap cycle, 3 = done cycle; cur = -1 means idle.
    int         sched [NDUT][SMAX];
    int         slen  [NDUT];
    int         pos   [NDUT];
    int         cur   [NDUT];
    logic [3:0] hist  [NDUT];
    int         hcnt  [NDUT];
    logic       flag_m[NDUT];

    function automatic int gap_of(input int k);
        return (k == 0) ? 0 : k + 1;
    endfunction

    function automatic logic idle_of(input int k);
        return (k == 1);
    endfunction

    function automatic logic any_busy();
        for (int k = 0; k < NDUT; k++) if (cur[k] != -1) return 1'b1;
        return 1'b0;
    endfunction

    task automatic build(input int k);
        int eff;
        eff = ((in_len == 0) || (in_len > 16)) ? 16 : int'(in_len);
        slen[k] = 0;
        for (int r = 0; r <= int'(in_rep); r++) begin
            for (int i = eff - 1; i >= 0; i--) begin
                sched[k][slen[k]] = in_data[i] ? 1 : 0;
                slen[k]++;
            end
            if (r < int'(in_rep)) begin
                for (int g = 0; g < gap_of(k); g++) begin
                    sched[k][slen[k]] = 2;
                    slen[k]++;
                end
            end
        end
        sched[k][slen[k]] = 3;
        slen[k]++;
    endtask

    task automatic model_step(input int k);
        if (rst) begin
            cur[k]    = -1;
            hcnt[k]   = 0;
            hist[k]   = '0;
            flag_m[k] = 1'b0;
        end else begin
            if (cur[k] == -1 || abort) begin
                hcnt[k]   = 0;
                hist[k]   = '0;
                flag_m[k] = 1'b0;
            end else if (cur[k] <= 1) begin
                hist[k]   = {hist[k][2:0], (cur[k] == 1)};
                hcnt[k]++;
                flag_m[k] = (hcnt[k] >= 4) && (hist[k] == 4'b1101 || hist[k] == 4'b0110);
            end else begin
                flag_m[k] = 1'b0;
            end

            if (cur[k] != -1) begin
                if (abort) begin
                    cur[k] = -1;
                end else if (pos[k] < slen[k]) begin
                    cur[k] = sched[k][pos[k]];
                    pos[k]++;
                end else begin
                    cur[k] = -1;
                end
            end else if (in_valid && !abort) begin
                build(k);
                cur[k] = sched[k][0];
                pos[k] = 1;
            end
        end
    endtask

    task automatic chk(input string tag, input logic obs, input logic exp);
        tests++;
        assert (obs === exp) else begin
            failed++;
            $error("FAIL %s observed=%0b expected=%0b", tag, obs, exp);
        end
    endtask

    task automatic check_dut(input int k);
        logic edv;
        edv = (cur[k] == 0) || (cur[k] == 1);
        chk($sformatf("dut%0d dout_valid", k), dout_valid[k], edv);
        chk($sformatf("dut%0d dout", k), dout[k], edv ? (cur[k] == 1) : idle_of(k));
        chk($sformatf("dut%0d done", k), done[k], cur[k] == 3);
        chk($sformatf("dut%0d busy", k), busy[k], cur[k] != -1);
        chk($sformatf("dut%0d in_ready", k), in_ready[k], (cur[k] == -1) && !abort);
`ifdef SEQ_GEN_EXPECT_EN
        chk($sformatf("dut%0d expect_flag", k), expect_flag[k], flag_m[k]);
`endif
    endtask

    task automatic cycle();
        @(posedge clk);
        for (int k = 0; k < NDUT; k++) model_step(k);
        #1;
        for (int k = 0; k < NDUT; k++) check_dut(k);
    endtask

    task automatic drain();
        for (int n = 0; n < 4000 && any_busy(); n++) cycle();
        cycle();
    endtask

    task automatic send(input logic [15:0] d, input logic [4:0] l, input logic [3:0] r);
        in_data  = d;
        in_len   = l;
        in_rep   = r;
        in_valid = 1'b1;
        cycle();
        in_valid = 1'b0;
        drain();
    endtask

    initial begin
        for (int k = 0; k < NDUT; k++) begin
            cur[k] = -1; pos[k] = 0; slen[k] = 0;
            hist[k] = '0; hcnt[k] = 0; flag_m[k] = 1'b0;
        end

        // reset
        #2;
        rst = 1'b1;
        cycle();
        cycle();
        rst = 1'b0;
        cycle();

        // short word, single send
        send(16'h000D, 5'd4, 4'd0);
        // len 0 means full width
        send(16'hA5C3, 5'd0, 4'd0);
        // repeats with gaps
        send(16'h0006, 5'd4, 4'd2);
        // len above WIDTH means full width
        send(16'h8001, 5'd20, 4'd1);

        // abort during the 3rd bit, with a competing request in that cycle and the next
        in_data = 16'h00B4; in_len = 5'd8; in_rep = 4'd1;
        in_valid = 1'b1;
        cycle();
        in_valid = 1'b0;
        cycle();
        cycle();
        in_data = 16'h0055; abort = 1'b1; in_valid = 1'b1;
        cycle();
        cycle();
        abort = 1'b0; in_valid = 1'b0;
        cycle();

        // reset mid-SHIFT with in_valid held high
        in_data = 16'h00C9; in_len = 5'd8; in_rep = 4'd0;
        in_valid = 1'b1;
        cycle();
        cycle();
        cycle();
        rst = 1'b1;
        cycle();
        rst = 1'b0;
        cycle();
        cycle();
        in_valid = 1'b0;
        drain();

        // overlapping detector matches, also across repetitions and gaps
        send(16'h006D, 5'd7, 4'd0);
        send(16'h006D, 5'd7, 4'd1);
        // saturating repeat count: 16 sends
        send(16'h00B6, 5'd6, 4'hF);

        // randomized bursts with occasional aborts
        for (int t = 0; t < 40; t++) begin
            in_data  = 16'($urandom);
            in_len   = 5'($urandom_range(0, 31));
            in_rep   = ($urandom_range(0, 9) == 0) ? 4'hF : 4'($urandom_range(0, 3));
            in_valid = 1'b1;
            cycle();
            in_valid = 1'b0;
            in_data  = 16'($urandom);
            for (int n = 0; n < 4000 && any_busy(); n++) begin
                abort = ($urandom_range(0, 99) < 2);
                cycle();
                abort = 1'b0;
            end
            cycle();
        end

        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end

endmodule
